// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor (diff = a - b), one bit per clock, LSB first.
// Optional signed-overflow output is built only when SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fsub_bit(input logic x, input logic y, input logic br);
    logic d;
    logic bo;
    d  = x ^ y ^ br;
    bo = (~x & y) | (~x & br) | (y & br);
    return {bo, d};
  endfunction

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_sr_q,    a_sr_d;
  logic [WIDTH-1:0] b_sr_q,    b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             br_q,      br_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] diff_q,    diff_d;
  logic             bout_q,    bout_d;
`ifdef SUB_OVF_EN
  logic             ovf_q,     ovf_d;
`endif
  logic [1:0]       fs_s;

  // Next-state logic: FSM sequencing and one subtractor bit per RUN cycle.
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    diff_d    = diff_q;
    bout_d    = bout_q;
`ifdef SUB_OVF_EN
    ovf_d     = ovf_q;
`endif
    fs_s      = fsub_bit(a_sr_q[0], b_sr_q[0], br_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
        diff_sr_d = {fs_s[0], diff_sr_q[WIDTH-1:1]};
        br_d      = fs_s[1];
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Last bit: operand shift LSBs are now the captured MSBs.
          state_d = S_DONE;
          done_d  = 1'b1;
          diff_d  = {fs_s[0], diff_sr_q[WIDTH-1:1]};
          bout_d  = fs_s[1];
`ifdef SUB_OVF_EN
          ovf_d   = (a_sr_q[0] != b_sr_q[0]) && (fs_s[0] != a_sr_q[0]);
`endif
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_sr_q    <= {WIDTH{1'b0}};
      b_sr_q    <= {WIDTH{1'b0}};
      diff_sr_q <= {WIDTH{1'b0}};
      br_q      <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      diff_q    <= {WIDTH{1'b0}};
      bout_q    <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      br_q      <= br_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
`ifdef SUB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH=16).
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif

  int err_cnt;
  int chk_cnt;
  logic [15:0] prev_diff;

  serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic wait_done(input logic [15:0] ed, input logic eb, input logic eo,
                           input logic [15:0] prev, input bit scramble);
    int lat;
    int nbusy;
    bit seen;
    lat = 1;
    nbusy = 0;
    seen = 1'b0;
    check("busy_first", busy, 1'b1);
    if (busy) nbusy++;
    while (!seen && lat < 40) begin
      if (scramble) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      lat++;
      check("excl", busy & done, 1'b0);
      if (lat == 8) check("hold", diff, prev);
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    check("latency", lat, 17);
    check("busy_cnt", nbusy, 16);
    check("diff", diff, ed);
    check("bout", bout, eb);
`ifdef SUB_OVF_EN
    check("ovf", ovf, eo);
`endif
    @(negedge clk);
    check("pulse_end", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("diff_holds", diff, ed);
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] ed, input logic eb, input logic eo);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ed, eb, eo, prev_diff, 1'b0);
    prev_diff = ed;
  endtask

  initial begin
    logic [16:0] ref_s;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        ro;
    int          ndone;
    err_cnt = 0;
    chk_cnt = 0;
    prev_diff = 16'h0000;
    rst_n = 1'b0;
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 16'h0000);
    check("rst_bout", bout, 1'b0);
`ifdef SUB_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back-to-back.
    run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
    run_op(16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

    // Start held high, operands changing during RUN.
    a = 16'h0005;
    b = 16'h0003;
    start = 1'b1;
    @(negedge clk);
    wait_done(16'h0002, 1'b0, 1'b0, prev_diff, 1'b1);
    prev_diff = 16'h0002;
    a = 16'h0010;
    b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    wait_done(16'h000F, 1'b0, 1'b0, prev_diff, 1'b0);
    prev_diff = 16'h000F;

    // Reset during bit 7 of an operation.
    a = 16'hABCD;
    b = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 16'h0000);
    check("abort_bout", bout, 1'b0);
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    prev_diff = 16'h0000;

    // Random pairs.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ref_s = {1'b0, ra} - {1'b0, rb};
      ro = (ra[15] != rb[15]) && (ref_s[15] != ra[15]);
      run_op(ra, rb, ref_s[15:0], ref_s[16], ro);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
